// File: rtl/l2_mem_arbiter_pkg.sv
// Shared types for the L2 memory arbiter: line type, arbiter FSM states and
// the cache-line offset width.
package l2_mem_arbiter_pkg;

    localparam int LINE_OFFSET_BITS = 4;

    typedef logic [127:0] lc3b_line;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_RD   = 2'd2,
        D_WR   = 2'd3
    } lc3b_arb_state;

endpackage

// File: rtl/l2_arb_control.sv
// Grant FSM and round-robin last_grant tracking for the L2 arbiter.
// Produces grant-edge strobes, next-cycle pmem command and current-owner decode.
module l2_arb_control
    import l2_mem_arbiter_pkg::*;
#(
    parameter bit D_FIRST = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic i_req,
    input  logic d_read,
    input  logic d_write,
    input  logic pmem_resp,
    output logic grant_i_s,
    output logic grant_d_s,
    output logic grant_wr_s,
    output logic rd_next_s,
    output logic wr_next_s,
    output logic busy_i_s,
    output logic busy_d_s,
    output logic busy_d_rd_s
);

    lc3b_arb_state state_r;
    lc3b_arb_state next_state_s;
    logic          last_grant_r;        // 1 = D side was granted last
    logic          next_last_grant_s;
    logic          d_req_s;
    lc3b_arb_state d_cmd_s;

    assign d_req_s = d_read | d_write;
    // A simultaneous read+write from the D side is resolved as a writeback.
    assign d_cmd_s = d_write ? D_WR : D_RD;

    // State and round-robin history registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            last_grant_r <= ~D_FIRST;
        end else begin
            state_r      <= next_state_s;
            last_grant_r <= next_last_grant_s;
        end
    end

    // Next-state and last_grant update
    always_comb begin
        next_state_s      = state_r;
        next_last_grant_s = last_grant_r;
        case (state_r)
            IDLE: begin
                if (i_req && d_req_s) begin
                    if (last_grant_r) begin
                        next_state_s      = I_BUSY;
                        next_last_grant_s = 1'b0;
                    end else begin
                        next_state_s      = d_cmd_s;
                        next_last_grant_s = 1'b1;
                    end
                end else if (i_req) begin
                    next_state_s = I_BUSY;
                end else if (d_req_s) begin
                    next_state_s = d_cmd_s;
                end else begin
                    next_state_s = IDLE;
                end
            end
            I_BUSY, D_RD, D_WR: begin
                if (pmem_resp) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = state_r;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // Output decode of current and next state
    always_comb begin
        busy_i_s    = (state_r == I_BUSY);
        busy_d_rd_s = (state_r == D_RD);
        busy_d_s    = (state_r == D_RD) || (state_r == D_WR);
        grant_i_s   = (state_r == IDLE) && (next_state_s == I_BUSY);
        grant_d_s   = (state_r == IDLE) && ((next_state_s == D_RD) || (next_state_s == D_WR));
        grant_wr_s  = (state_r == IDLE) && (next_state_s == D_WR);
        rd_next_s   = (next_state_s == I_BUSY) || (next_state_s == D_RD);
        wr_next_s   = (next_state_s == D_WR);
    end

endmodule

// File: rtl/l2_mem_arbiter.sv
// Arbitrates I-cache fills and D-cache fills/writebacks onto one pmem port.
// Holds the request latches and the response/data muxing around l2_arb_control.
module l2_mem_arbiter
    import l2_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int LINE_W  = 128,
    parameter bit D_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    localparam logic [ADDR_W-1:0] LINE_MASK =
        {{(ADDR_W-LINE_OFFSET_BITS){1'b1}}, {LINE_OFFSET_BITS{1'b0}}};

    logic grant_i_s;
    logic grant_d_s;
    logic grant_wr_s;
    logic rd_next_s;
    logic wr_next_s;
    logic busy_i_s;
    logic busy_d_s;
    logic busy_d_rd_s;
    logic rd_done_s;

    logic              pmem_read_r;
    logic              pmem_write_r;
    logic [ADDR_W-1:0] addr_r;
    logic [LINE_W-1:0] wdata_r;
    logic [LINE_W-1:0] rdata_hold_r;

    l2_arb_control #(
        .D_FIRST (D_FIRST)
    ) u_control (
        .clk         (clk),
        .reset       (reset),
        .i_req       (i_read),
        .d_read      (d_read),
        .d_write     (d_write),
        .pmem_resp   (pmem_resp),
        .grant_i_s   (grant_i_s),
        .grant_d_s   (grant_d_s),
        .grant_wr_s  (grant_wr_s),
        .rd_next_s   (rd_next_s),
        .wr_next_s   (wr_next_s),
        .busy_i_s    (busy_i_s),
        .busy_d_s    (busy_d_s),
        .busy_d_rd_s (busy_d_rd_s)
    );

    assign rd_done_s = (busy_i_s | busy_d_rd_s) & pmem_resp;

    // pmem strobes, grant-time request latches and last read-data copy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pmem_read_r  <= 1'b0;
            pmem_write_r <= 1'b0;
            addr_r       <= {ADDR_W{1'b0}};
            wdata_r      <= {LINE_W{1'b0}};
            rdata_hold_r <= {LINE_W{1'b0}};
        end else begin
            pmem_read_r  <= rd_next_s;
            pmem_write_r <= wr_next_s;
            if (grant_i_s) begin
                addr_r <= i_address & LINE_MASK;
            end else if (grant_d_s) begin
                addr_r <= d_address & LINE_MASK;
            end
            if (grant_wr_s) begin
                wdata_r <= d_wdata;
            end
            if (rd_done_s) begin
                rdata_hold_r <= pmem_rdata;
            end
        end
    end

    assign pmem_read    = pmem_read_r;
    assign pmem_write   = pmem_write_r;
    assign pmem_address = addr_r;
    assign pmem_wdata   = wdata_r;

    // Completion is forwarded in the same cycle only to the side that owns pmem.
    assign i_resp  = busy_i_s & pmem_resp;
    assign d_resp  = busy_d_s & pmem_resp;
    assign i_rdata = i_resp ? pmem_rdata : rdata_hold_r;
    assign d_rdata = (busy_d_rd_s & pmem_resp) ? pmem_rdata : rdata_hold_r;

endmodule

// File: tb/tb_l2_mem_arbiter.sv
// Scoreboard bench for l2_mem_arbiter: directed scenarios followed by randomized
// clients against a transaction-level arbitration model.
module tb_l2_mem_arbiter;

    localparam int ADDR_W  = 16;
    localparam int LINE_W  = 128;
    localparam bit D_FIRST = 1'b1;
    localparam logic [ADDR_W-1:0] ADDR_MASK = 16'hFFF0;

    logic              clk = 1'b0;
    logic              reset;
    logic              i_read;
    logic [ADDR_W-1:0] i_address;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;
    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_address;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;
    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit                d;
        bit                w;
        logic [LINE_W-1:0] data;
    } exp_t;
    exp_t exp_q[$];
    bit   grant_log[$];

    // Transaction-level model state
    bit                granted;
    bit                cur_d;
    bit                cur_w;
    bit                lg_d;
    bit                auto_resp;
    logic [ADDR_W-1:0] cur_addr;
    logic [LINE_W-1:0] cur_wdata;
    bit                prev_strobe;
    bit                prev_i;
    bit                prev_d;
    bit                prev_dw;
    logic [ADDR_W-1:0] prev_iaddr;
    logic [ADDR_W-1:0] prev_daddr;
    logic [LINE_W-1:0] prev_dwdata;

    l2_mem_arbiter #(
        .ADDR_W  (ADDR_W),
        .LINE_W  (LINE_W),
        .D_FIRST (D_FIRST)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_read       (i_read),
        .i_address    (i_address),
        .i_rdata      (i_rdata),
        .i_resp       (i_resp),
        .d_read       (d_read),
        .d_write      (d_write),
        .d_address    (d_address),
        .d_wdata      (d_wdata),
        .d_rdata      (d_rdata),
        .d_resp       (d_resp),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [LINE_W-1:0] rnd_line();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Observes pmem and client responses once per cycle on the falling edge.
    task automatic monitor();
        bit   strobe;
        bit   side_d;
        exp_t e;
        forever begin
            @(negedge clk);
            strobe = pmem_read | pmem_write;
            if (reset) begin
                lg_d        = !D_FIRST;
                granted     = 1'b0;
                exp_q.delete();
                prev_strobe = 1'b0;
                prev_i      = 1'b0;
                prev_d      = 1'b0;
            end else begin
                chk("strobe_exclusive", pmem_read & pmem_write, 1'b0);
                if (strobe && !prev_strobe) begin
                    chk("grant_cause", prev_i | prev_d, 1'b1);
                    if (prev_i && prev_d) begin
                        side_d = !lg_d;
                        lg_d   = side_d;
                    end else begin
                        side_d = prev_d;
                    end
                    cur_d     = side_d;
                    cur_w     = side_d && prev_dw;
                    cur_addr  = (side_d ? prev_daddr : prev_iaddr) & ADDR_MASK;
                    cur_wdata = prev_dwdata;
                    chk("grant_cmd", {pmem_read, pmem_write}, cur_w ? 2'b01 : 2'b10);
                    chk("grant_addr", pmem_address, cur_addr);
                    if (cur_w) chk("grant_wdata", pmem_wdata, cur_wdata);
                    granted = 1'b1;
                    grant_log.push_back(side_d);
                end else if (strobe) begin
                    chk("hold_cmd", {pmem_read, pmem_write}, cur_w ? 2'b01 : 2'b10);
                    chk("hold_addr", pmem_address, cur_addr);
                    if (cur_w) chk("hold_wdata", pmem_wdata, cur_wdata);
                end else if (!prev_strobe && (prev_i || prev_d)) begin
                    chk("grant_latency", strobe, 1'b1);
                end
                if (pmem_resp && !strobe) chk("stray_resp", {i_resp, d_resp}, 2'b00);
                if (i_resp || d_resp || (pmem_resp && strobe)) begin
                    if (exp_q.size() == 0) begin
                        chk("resp_queue", exp_q.size(), 1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("resp_side", {i_resp, d_resp}, e.d ? 2'b01 : 2'b10);
                        if (!e.w) chk("resp_rdata", e.d ? d_rdata : i_rdata, e.data);
                    end
                    granted = 1'b0;
                end
            end
            prev_strobe = strobe;
            prev_i      = i_read;
            prev_d      = d_read | d_write;
            prev_dw     = d_write;
            prev_iaddr  = i_address;
            prev_daddr  = d_address;
            prev_dwdata = d_wdata;
        end
    endtask

    // Random-latency physical memory, including occasional stray completions.
    task automatic responder();
        logic [LINE_W-1:0] data;
        forever begin
            tick();
            if (auto_resp) begin
                if (pmem_resp) begin
                    pmem_resp = 1'b0;
                end else if (granted && ($urandom_range(0, 2) == 0)) begin
                    data       = rnd_line();
                    pmem_resp  = 1'b1;
                    pmem_rdata = data;
                    exp_q.push_back('{cur_d, cur_w, data});
                end else if (!(pmem_read | pmem_write) && ($urandom_range(0, 7) == 0)) begin
                    pmem_resp  = 1'b1;
                    pmem_rdata = rnd_line();
                end
            end
        end
    endtask

    task automatic pulse(input logic [LINE_W-1:0] data, input bit ei, input bit ed);
        tick();
        pmem_resp  = 1'b1;
        pmem_rdata = data;
        if (pmem_read | pmem_write) exp_q.push_back('{cur_d, cur_w, data});
        @(negedge clk);
        chk("pulse_resp", {i_resp, d_resp}, {ei, ed});
        if (ei) chk("pulse_i_rdata", i_rdata, data);
        tick();
        pmem_resp = 1'b0;
    endtask

    task automatic raise(input bit is_d, input bit chaos);
        int cmd;
        if (is_d) begin
            cmd       = chaos ? $urandom_range(0, 9) : 0;
            d_read    = (cmd < 5) || (cmd == 9);
            d_write   = (cmd >= 5);
            d_address = ADDR_W'($urandom());
            d_wdata   = rnd_line();
        end else begin
            i_read    = 1'b1;
            i_address = ADDR_W'($urandom());
        end
    endtask

    task automatic client(input bit is_d, input int n, input int gap_max, input bit chaos);
        bit got;
        for (int t = 0; t < n; t++) begin
            got = 1'b0;
            repeat ($urandom_range(0, gap_max)) @(posedge clk);
            tick();
            raise(is_d, chaos);
            for (int c = 0; c < 400 && !got; c++) begin
                @(negedge clk);
                if (is_d ? d_resp : i_resp) begin
                    got = 1'b1;
                end else begin
                    tick();
                    if (chaos && ($urandom_range(0, 3) == 0)) begin
                        if (is_d) begin
                            d_address = ADDR_W'($urandom());
                            d_wdata   = rnd_line();
                        end else begin
                            i_address = ADDR_W'($urandom());
                        end
                    end
                end
            end
            chk(is_d ? "d_client_done" : "i_client_done", got, 1'b1);
            tick();
            if (is_d) begin
                d_read  = 1'b0;
                d_write = 1'b0;
            end else begin
                i_read = 1'b0;
            end
        end
    endtask

    initial begin
        reset      = 1'b1;
        i_read     = 1'b0;
        i_address  = 16'h0000;
        d_read     = 1'b0;
        d_write    = 1'b0;
        d_address  = 16'h0000;
        d_wdata    = {LINE_W{1'b0}};
        pmem_rdata = {LINE_W{1'b0}};
        pmem_resp  = 1'b0;
        auto_resp  = 1'b0;
        lg_d       = !D_FIRST;
        fork
            monitor();
            responder();
        join_none

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("reset_ctl", {pmem_read, pmem_write, i_resp, d_resp}, 4'b0000);
            chk("reset_addr", pmem_address, 16'h0000);
            chk("reset_wdata", pmem_wdata, {LINE_W{1'b0}});
        end

        // Single I fill
        tick();
        i_read    = 1'b1;
        i_address = 16'h1237;
        @(negedge clk);
        chk("i_fill_early", pmem_read, 1'b0);
        @(negedge clk);
        chk("i_fill_read", pmem_read, 1'b1);
        chk("i_fill_addr", pmem_address, 16'h1230);
        pulse({4{32'hDEADBEEF}}, 1'b1, 1'b0);
        i_read = 1'b0;
        @(negedge clk);
        chk("i_fill_drop", pmem_read, 1'b0);

        // D writeback with data changed after the grant
        tick();
        d_write   = 1'b1;
        d_address = 16'h4000;
        d_wdata   = {16{8'hA5}};
        repeat (2) @(negedge clk);
        tick();
        d_wdata = {16{8'h5A}};
        repeat (3) begin
            @(negedge clk);
            chk("wb_write", pmem_write, 1'b1);
            chk("wb_wdata", pmem_wdata, {16{8'hA5}});
        end
        pulse(rnd_line(), 1'b0, 1'b1);
        d_write = 1'b0;

        // D read with address changed mid-service
        tick();
        d_read    = 1'b1;
        d_address = 16'h2000;
        repeat (2) @(negedge clk);
        tick();
        d_address = 16'h3000;
        @(negedge clk);
        chk("drd_addr_hold", pmem_address, 16'h2000);
        pulse(rnd_line(), 1'b0, 1'b1);
        d_read = 1'b0;

        // Stray completion while idle
        tick();
        pmem_resp = 1'b1;
        @(negedge clk);
        chk("stray_idle", {i_resp, d_resp, pmem_read, pmem_write}, 4'b0000);
        tick();
        pmem_resp = 1'b0;
        @(negedge clk);
        chk("stray_state", {pmem_read, pmem_write}, 2'b00);

        // Request withdrawn mid-service still completes
        tick();
        i_read    = 1'b1;
        i_address = 16'h7ABC;
        repeat (2) @(negedge clk);
        tick();
        i_read = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("withdraw_hold", pmem_read, 1'b1);
        end
        pulse(rnd_line(), 1'b1, 1'b0);

        // Read+write together is a writeback; then reset mid-D_WR
        tick();
        d_read    = 1'b1;
        d_write   = 1'b1;
        d_address = 16'h5555;
        d_wdata   = rnd_line();
        repeat (2) @(negedge clk);
        chk("illegal_cmd", {pmem_read, pmem_write}, 2'b01);
        #2;
        reset   = 1'b1;
        d_read  = 1'b0;
        d_write = 1'b0;
        #1;
        chk("reset_async", {pmem_read, pmem_write, i_resp, d_resp}, 4'b0000);
        @(negedge clk);
        tick();
        reset = 1'b0;

        // Contention from reset: D first, then strict alternation
        grant_log.delete();
        auto_resp = 1'b1;
        fork
            client(1'b0, 3, 0, 1'b0);
            client(1'b1, 3, 0, 1'b0);
        join
        chk("alt_count", grant_log.size(), 6);
        for (int i = 0; i < grant_log.size() && i < 6; i++) begin
            chk("alt_order", grant_log[i], (i % 2 == 0) ? 1'b1 : 1'b0);
        end

        // Randomized traffic
        fork
            client(1'b0, 40, 4, 1'b1);
            client(1'b1, 40, 4, 1'b1);
        join
        repeat (10) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
